// File: rtl/cnn_pkg.sv
// Shared definitions for the padded-row window block: FSM encoding and row-width helpers.
package cnn_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_SLIDE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    HOLD  = ST_HOLD,
    SLIDE = ST_SLIDE
  } state_e;

  localparam int ROW_PIX_DEF = 418;
  localparam int PIX_W_DEF   = 8;
  localparam int CH_DEF      = 3;

  // Row-slice width for the default geometry; parameterised instances use row_w().
  localparam int ROW_W = ROW_PIX_DEF * PIX_W_DEF * CH_DEF;

  function automatic int row_w(input int row_pix, input int pix_w, input int ch);
    return row_pix * pix_w * ch;
  endfunction

endpackage

// File: rtl/row_shift_bank.sv
// K row registers with indexed load (initial fill) and shift-in (slide by one row).
module row_shift_bank #(
  parameter int K     = 3,
  parameter int ROW_W = 8,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic               shift_en,
  input  logic [ROW_W-1:0]   din,
  output logic [K*ROW_W-1:0] rows
);

  // Index 0 sits in the low bits, so the packed array is already the output layout.
  logic [K-1:0][ROW_W-1:0] row_q;
  logic [K-1:0][ROW_W-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (shift_en) begin
      row_d = {din, row_q[K-1:1]};
    end else if (load_en) begin
      for (int r = 0; r < K; r++) begin
        if (load_idx == IDX_W'(r)) row_d[r] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) row_q <= '0;
    else       row_q <= row_d;
  end

  assign rows = row_q;

endmodule

// File: rtl/padded_row_window.sv
// Collects padded rows into a K-row sliding window and hands one window per slide
// to the consumer; FSM and counters live here, row storage in row_shift_bank.
module padded_row_window
  import cnn_pkg::*;
#(
  parameter int ROW_PIX    = 418,
  parameter int PIX_W      = 8,
  parameter int CH         = 3,
  parameter int K          = 3,
  parameter int FRAME_ROWS = 418
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    frame_start,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [row_w(ROW_PIX, PIX_W, CH)-1:0]    in_row,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [K*row_w(ROW_PIX, PIX_W, CH)-1:0]  out_window,
  output logic [$clog2(FRAME_ROWS)-1:0]           win_idx,
  output logic                                    last_win,
  output state_e                                  dbg_state
);

  localparam int ROW_BITS = row_w(ROW_PIX, PIX_W, CH);
  localparam int WIN_W    = $clog2(FRAME_ROWS);
  localparam int CNT_W    = $clog2(K);
  localparam logic [WIN_W-1:0] LAST_IDX  = WIN_W'(FRAME_ROWS - K);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(K - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               load_en, shift_en;

  // Handshake: a row transfers on a rising edge with in_valid && in_ready, a window
  // with out_valid && out_ready. Both ready/valid outputs depend on state only, so
  // neither side sees a combinational path through this block.
  assign in_ready  = (state_q == FILL) || (state_q == SLIDE);
  assign out_valid = (state_q == HOLD);
  assign last_win  = out_valid && (win_q == LAST_IDX);
  assign win_idx   = win_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    // A new frame wins over any pending row or window transfer.
    if (frame_start) begin
      state_d = FILL;
      cnt_d   = '0;
      win_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FILL: begin
          if (in_valid) begin
            load_en = 1'b1;
            if (cnt_q == FILL_LAST) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = last_win ? IDLE : SLIDE;
        end
        SLIDE: begin
          if (in_valid) begin
            shift_en = 1'b1;
            win_d    = win_q + 1'b1;
            state_d  = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  row_shift_bank #(
    .K     (K),
    .ROW_W (ROW_BITS),
    .IDX_W (CNT_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .load_idx (cnt_q),
    .shift_en (shift_en),
    .din      (in_row),
    .rows     (out_window)
  );

endmodule

// File: doc/padded_row_window.md
PADDED_ROW_WINDOW -- requirements
Module: padded_row_window

Interface
REQ-001 SHALL have parameter ROW_PIX, default 418, meaning padded pixels per row.
REQ-002 SHALL have parameter PIX_W, default 8, meaning bits per pixel per channel.
REQ-003 SHALL have parameter CH, default 3, meaning channel count.
REQ-004 SHALL have parameter K, default 3, meaning window height in rows (K>=2).
REQ-005 SHALL have parameter FRAME_ROWS, default 418, meaning padded rows per frame (FRAME_ROWS>=K).
REQ-006 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port: frame_start  input  1  one-cycle pulse starting a new frame.
REQ-009 SHALL have port: in_valid  input  1  in_row holds a valid row.
REQ-010 SHALL have port: in_ready  output  1  block accepts a row this cycle.
REQ-011 SHALL have port: in_row  input  ROW_PIX*PIX_W*CH  one padded row, channel c at slice [c*ROW_PIX*PIX_W +: ROW_PIX*PIX_W].
REQ-012 SHALL have port: out_valid  output  1  out_window holds a complete window.
REQ-013 SHALL have port: out_ready  input  1  consumer takes window this cycle.
REQ-014 SHALL have port: out_window  output  K*ROW_PIX*PIX_W*CH  K rows, oldest row at index 0 (slice [r*ROW_PIX*PIX_W*CH +: ROW_PIX*PIX_W*CH]).
REQ-015 SHALL have port: win_idx  output  clog2(FRAME_ROWS)  index of current window, 0-based.
REQ-016 SHALL have port: last_win  output  1  high with out_valid when win_idx == FRAME_ROWS-K.

Function
REQ-017 SHALL implement states IDLE, FILL, HOLD, SLIDE.
REQ-018 IDLE: in_ready=0, out_valid=0; frame_start -> FILL with fill count and win_idx cleared.
REQ-019 FILL: in_ready=1; each accept (in_valid&&in_ready) writes in_row to row[fill count], increments count; Kth accept -> HOLD.
REQ-020 HOLD: out_valid=1, in_ready=0, window stable; out_ready and !last_win -> SLIDE; out_ready and last_win -> IDLE.
REQ-021 SLIDE: in_ready=1, out_valid=0; accept shifts row[r]<=row[r+1] for r<K-1, row[K-1]<=in_row, win_idx increments, -> HOLD.
REQ-022 out_valid SHALL rise the cycle after the accept completing a window (latency 1 cycle); out_window SHALL never change while out_valid=1.
REQ-023 Windows per frame SHALL be exactly FRAME_ROWS-K+1; rows offered after the last window SHALL not be accepted (in_ready=0 in IDLE).
REQ-024 frame_start in any non-IDLE state SHALL abort the frame: -> FILL, count and win_idx cleared, row storage retained but overwritten by refill; frame_start has priority over a simultaneous accept or out_ready.
REQ-025 in_valid low SHALL stall FILL/SLIDE indefinitely without state change; out_ready low SHALL stall HOLD indefinitely.
REQ-026 Outputs SHALL be driven to known values at all times; no high-impedance drive.

Reset
REQ-027 reset SHALL force state IDLE, fill count 0, win_idx 0, all row storage and out_window 0, in_ready 0, out_valid 0, last_win 0.
REQ-028 reset asserted mid-frame SHALL take priority over all inputs and discard the partial frame.

Structure
REQ-029 State encoding localparams and the row-slice width ROW_W=ROW_PIX*PIX_W*CH SHALL reside in shared package cnn_pkg.
REQ-030 Row storage SHALL be a single sub-module row_shift_bank (K registers of ROW_W, load-at-index and shift-in ports); FSM and counters in the top.

Verification
REQ-031 Reset then frame_start, 3 rows A,B,C with in_valid held -> out_valid one cycle after C accept, window {A,B,C}, win_idx 0.
REQ-032 In HOLD, out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, window unchanged; then out_ready=1, row D -> window {B,C,D}, win_idx 1.
REQ-033 Full frame FRAME_ROWS=418, K=3 -> exactly 416 windows, last_win only on win_idx 415, then IDLE and in_ready=0.
REQ-034 frame_start asserted in SLIDE with concurrent in_valid -> row not shifted, state FILL, win_idx 0; next 3 rows form window 0.
REQ-035 reset pulse during HOLD -> next cycle out_valid=0, out_window all zero, state IDLE.
REQ-036 Parameter set ROW_PIX=10, PIX_W=4, CH=1, K=5, FRAME_ROWS=7 -> 3 windows with correct row ordering.
